// File: rtl/mmd_pkg.sv
// mmd_pkg: shared states, default ratio bounds and the clamp rule for the MMD divider
package mmd_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  localparam int DIV_W_D = 4;
  localparam int MIN_DIV_D = 3;
  localparam int MAX_DIV_D = 11;
  localparam int PCNT_W_D = 16;
  function automatic int clamp_ratio(int v, int lo, int hi);
    return v < lo ? lo : (v > hi ? hi : v);
  endfunction
endpackage

// File: rtl/mmd_divider_if.sv
// mmd_divider_if: modulator-side handshake and divider outputs
interface mmd_divider_if import mmd_pkg::*; #(
  parameter int DIV_W = DIV_W_D,
  parameter int PCNT_W = PCNT_W_D
);
  logic en;
  logic [DIV_W-1:0] div_in;
  logic div_req;
  logic div_pulse;
  logic div_clk;
  logic [DIV_W-1:0] n_cur;
  logic [PCNT_W-1:0] pcnt;
  logic div_err;
  modport master(output en, div_in, input div_req, div_pulse, div_clk, n_cur, pcnt, div_err);
  modport slave(input en, div_in, output div_req, div_pulse, div_clk, n_cur, pcnt, div_err);
endinterface

// File: rtl/mmd_divider_clamp.sv
// div_ratio_clamp: limits a requested ratio to [MIN_DIV, MAX_DIV] and flags out-of-range values
module div_ratio_clamp import mmd_pkg::*; #(
  parameter int DIV_W = DIV_W_D,
  parameter int MIN_DIV = MIN_DIV_D,
  parameter int MAX_DIV = MAX_DIV_D
) (
  input  logic [DIV_W-1:0] div_in,
  output logic [DIV_W-1:0] nc,
  output logic             oor
);
  int lim;
  assign lim = clamp_ratio(int'(div_in), MIN_DIV, MAX_DIV);
  assign nc = DIV_W'(lim);
  assign oor = lim != int'(div_in);
endmodule

// File: rtl/mmd_divider.sv
// mmd_divider: multi-modulus divider after the MASH modulator; MMD_DUTY50_EN adds a ~50% duty div_clk
module mmd_divider import mmd_pkg::*; #(
  parameter int DIV_W = DIV_W_D,
  parameter int MIN_DIV = MIN_DIV_D,
  parameter int MAX_DIV = MAX_DIV_D,
  parameter int PCNT_W = PCNT_W_D
) (
  input logic clk,
  input logic rst,
  mmd_divider_if.slave bus
);
  state_t state, state_n;
  logic [DIV_W-1:0] cnt, cnt_n, n_cur, n_cur_n, nc;
  logic [PCNT_W-1:0] pcnt, pcnt_n;
  logic oor, sample, req, err, err_n;
  div_ratio_clamp #(.DIV_W(DIV_W), .MIN_DIV(MIN_DIV), .MAX_DIV(MAX_DIV)) u_clamp (
    .div_in(bus.div_in),
    .nc(nc),
    .oor(oor)
  );
  always_comb begin
    sample = bus.en && (state == IDLE || cnt == '0);
    state_n = bus.en ? RUN : state;
    cnt_n = !bus.en ? cnt : sample ? nc - DIV_W'(1) : cnt - DIV_W'(1);
    n_cur_n = sample ? nc : n_cur;
    pcnt_n = (sample && state == RUN) ? pcnt + PCNT_W'(1) : pcnt;
    err_n = err || (sample && oor);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      n_cur <= DIV_W'(MIN_DIV);
      pcnt <= '0;
      req <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      n_cur <= n_cur_n;
      pcnt <= pcnt_n;
      req <= sample;
      err <= err_n;
    end
  end
`ifdef MMD_DUTY50_EN
  logic dclk;
  // high while the countdown is in the upper half, giving ceil(N/2) high cycles
  always_ff @(posedge clk) dclk <= rst ? 1'b0 : bus.en ? (cnt_n >= (n_cur_n >> 1)) : dclk;
  assign bus.div_clk = dclk;
`else
  assign bus.div_clk = req;
`endif
  assign bus.div_req = req;
  assign bus.div_pulse = req;
  assign bus.n_cur = n_cur;
  assign bus.pcnt = pcnt;
  assign bus.div_err = err;
endmodule

// File: tb/tb_mmd_divider.sv
// tb_mmd_divider: table, directed and randomized checks of mmd_divider against a period-level model
module tb_mmd_divider;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mmd_divider_if #(.DIV_W(4), .PCNT_W(16)) bus();
  mmd_divider dut(.clk(clk), .rst(rst), .bus(bus));
  typedef struct {int din; int n; int err;} vec_t;
  vec_t tbl[9];
  int checks = 0;
  int errors = 0;
  logic m_started = 1'b0, m_pulse = 1'b0, m_clk = 1'b0, m_err = 1'b0;
  int m_since = 0, m_n = 3, m_pcnt = 0;
  function automatic int clampf(int v);
    return v < 3 ? 3 : (v > 11 ? 11 : v);
  endfunction
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_edge();
    if (rst) begin
      m_started = 1'b0; m_since = 0; m_n = 3; m_pcnt = 0; m_err = 1'b0; m_pulse = 1'b0; m_clk = 1'b0;
    end else if (bus.en) begin
      if (!m_started || m_since == m_n) begin
        if (m_started) m_pcnt = (m_pcnt + 1) % 65536;
        m_n = clampf(int'(bus.div_in));
        m_err = m_err | (m_n != int'(bus.div_in));
        m_since = 1; m_pulse = 1'b1; m_started = 1'b1;
      end else begin
        m_since++; m_pulse = 1'b0;
      end
`ifdef MMD_DUTY50_EN
      m_clk = (m_since - 1) < (m_n + 1) / 2;
`endif
    end else m_pulse = 1'b0;
`ifndef MMD_DUTY50_EN
    m_clk = m_pulse;
`endif
  endtask
  task automatic step();
    model_edge();
    @(posedge clk); #1;
    chk("div_pulse", int'(bus.div_pulse), int'(m_pulse));
    chk("div_req", int'(bus.div_req), int'(m_pulse));
    chk("n_cur", int'(bus.n_cur), m_n);
    chk("pcnt", int'(bus.pcnt), m_pcnt);
    chk("div_err", int'(bus.div_err), int'(m_err));
    chk("div_clk", int'(bus.div_clk), int'(m_clk));
  endtask
  task automatic run_to_pulse(output int c);
    c = 0;
    do begin step(); c++; end while (!bus.div_pulse && c < 40);
    if (!bus.div_pulse) chk("pulse_timeout", 0, 1);
  endtask
  task automatic do_reset();
    rst = 1'b1; bus.en = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask
  initial begin
    int c;
    int seq[4];
    bus.en = 1'b0; bus.div_in = 4'd4;
    tbl = '{'{0,3,1}, '{1,3,1}, '{2,3,1}, '{3,3,0}, '{4,4,0}, '{7,7,0}, '{11,11,0}, '{12,11,1}, '{15,11,1}};
    seq = '{3, 11, 7, 4};
    do_reset();
    chk("reset_n_cur", int'(bus.n_cur), 3);
    chk("reset_pulse", int'(bus.div_pulse), 0);
    for (int i = 0; i < 9; i++) begin
      do_reset();
      bus.div_in = 4'(tbl[i].din); bus.en = 1'b1;
      step();
      chk("tbl_n_cur", int'(bus.n_cur), tbl[i].n);
      chk("tbl_err", int'(bus.div_err), tbl[i].err);
      chk("tbl_req", int'(bus.div_req), 1);
    end
    do_reset();
    bus.div_in = 4'd4; bus.en = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      run_to_pulse(c);
      chk("const4_spacing", c, 4);
      chk("const4_pcnt", int'(bus.pcnt), k + 1);
    end
    do_reset();
    bus.div_in = 4'd3; bus.en = 1'b1;
    step();
    for (int k = 1; k < 4; k++) begin
      bus.div_in = 4'(seq[k]);
      run_to_pulse(c);
      chk("seq_spacing", c, seq[k-1]);
      chk("seq_n_cur", int'(bus.n_cur), seq[k]);
    end
    do_reset();
    bus.div_in = 4'd1; bus.en = 1'b1;
    step();
    bus.div_in = 4'd15;
    run_to_pulse(c);
    chk("clamp_lo_period", c, 3);
    bus.div_in = 4'd5;
    run_to_pulse(c);
    chk("clamp_hi_period", c, 11);
    chk("err_sticky", int'(bus.div_err), 1);
    do_reset();
    chk("err_cleared", int'(bus.div_err), 0);
    do_reset();
    bus.div_in = 4'd6; bus.en = 1'b1;
    step(); step(); step();
    bus.en = 1'b0;
    repeat (5) begin
      step();
      chk("freeze_nopulse", int'(bus.div_pulse), 0);
      chk("freeze_pcnt", int'(bus.pcnt), 0);
    end
    bus.en = 1'b1;
    run_to_pulse(c);
    chk("freeze_period", 2 + 5 + c, 11);
    chk("freeze_pcnt_after", int'(bus.pcnt), 1);
    do_reset();
    bus.div_in = 4'd4; bus.en = 1'b1;
    step();
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_req", int'(bus.div_req), 0);
    chk("midrst_n_cur", int'(bus.n_cur), 3);
    chk("midrst_clk", int'(bus.div_clk), 0);
    step();
    chk("midrst_restart", int'(bus.div_req), 1);
    do_reset();
    repeat (3000) begin
      bus.en = $urandom_range(0, 7) != 0;
      bus.div_in = 4'($urandom_range(0, 15));
      rst = $urandom_range(0, 299) == 0;
      step();
    end
    rst = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
